plb_dac_user_logic: RTL and testbench
=====================================

Name: plb_dac_user_logic

Overview:
- PLB IPIF user-logic slave for a 10-bit parallel DAC.
- Provides 7 software registers through Bus2IP chip-enables.
- Generates a divided DAC sample clock and a 10-bit sample stream: direct value, sawtooth, triangle, square or down-ramp.
- Drives the DAC static control pins from the control register.

Parameters:
C_SLV_DWIDTH, 32, bus data width (fixed 32)
C_NUM_REG, 7, number of software registers (RdCE/WrCE width)

Ports:
Bus2IP_Clk  in  1  system clock
Bus2IP_Reset  in  1  reset, asynchronous, active-low
Bus2IP_Addr  in  32  address (unused)
Bus2IP_CS  in  1  chip select (unused)
Bus2IP_RNW  in  1  read-not-write (unused)
Bus2IP_Data  in  [0:31]  write data, bit 0 = MSB
Bus2IP_BE  in  [0:3]  byte enables, BE[0] = Data[0:7]
Bus2IP_RdCE  in  [0:6]  one-hot read enables, bit 0 = reg0
Bus2IP_WrCE  in  [0:6]  one-hot write enables, bit 0 = reg0
IP2Bus_Data  out  [0:31]  read data
IP2Bus_RdAck / IP2Bus_WrAck / IP2Bus_Error  out  1 each
IP2DAC_Data  out  [0:9]  sample, bit 0 = MSB, offset binary
IP2DAC_DCLKIO, IP2DAC_Clkout  out  1  DAC sample clock
IP2DAC_PinMD, IP2DAC_ClkMD, IP2DAC_PWRDN, IP2DAC_OpEnI, IP2DAC_OpEnQ  out  1  DAC control pins
IP2DAC_Format_I / _O / _T  in/out/out  1  Format pin tristate triple

Behaviour:
- One clock domain. Reset is asynchronous and active-low on Bus2IP_Reset; all registers clear to 0.
- Field bits below are numeric; bit 0 = LSB = Bus2IP_Data[31].
- Writes: register k loads on a clock where WrCE[k]=1, byte-masked by BE.
- IP2Bus_WrAck = OR(WrCE) and IP2Bus_RdAck = OR(RdCE), both combinational. IP2Bus_Error = 0.
- IP2Bus_Data is a combinational mux selected by RdCE; it is 0 when no RdCE is set.
- reg0 CTRL:
  - [0] EN
  - [7:4] MODE
  - [8] PinMD, [9] ClkMD, [10] Format_O
  - [11] FmtDrive: Format_T = ~bit11
  - [12] PWRDN request
  - [13] OpEnI, [14] OpEnQ
  - [31:16] DIV N
- reg1 LEVEL[9:0]. reg2 STEP[9:0]. reg3, reg5, reg6: R/W scratch.
- reg4 STATUS, read-only, writes ignored: [9:0] current sample, [16] Format_I, other bits 0.
- Pin outputs:
  - PWRDN = bit12 | ~EN.
  - OpEnI = bit13 & EN; OpEnQ = bit14 & EN.
  - Other pins follow their bits directly.
- Reset pin values: Format_T=1, PWRDN=1, all other outputs 0.
- Divider:
  - Effective N = max(N,2).
  - 16-bit counter c runs 0..N-1 while EN=1 and wraps to 0.
  - Tick = cycle where c==N-1.
  - DCLKIO = Clkout = (c >= N/2, floor), registered. With N=500 this gives 250 clocks low then 250 high; data changes while the clock is low.
  - If N is rewritten so that c >= N-1, the next cycle wraps.
- EN=0: c=0, DCLKIO=0, accumulator ACC=0, direction=up, IP2DAC_Data=0.
- Sample update: data register updates on the clock after each tick (first tick after N clocks).
  - MODE 0: LEVEL.
  - MODE 1 sawtooth: ACC += STEP mod 1024.
  - MODE 2 triangle:
    - Going up: ACC+STEP > 1023 gives 1023 and flips direction to down.
    - Going down: ACC < STEP gives 0 and flips direction to up.
  - MODE 3 square: internal sawtooth runs; output = LEVEL while sawtooth bit 9 = 0, else 0.
  - MODE 4: ACC -= STEP mod 1024.
  - Other MODE values: treated as MODE 0.
  - Output = ACC (or LEVEL) after the update.
- A MODE change while running keeps ACC and the counter; only direction resets to up.
- STEP=0: output holds constant.

Test Plan:
- Hold Bus2IP_Reset=0 → reset values:
  - All reads return 0, except reg4[16] = Format_I.
  - IP2DAC_Data=0, Format_T=1, PWRDN=1, DCLKIO=0.
- Release reset, set BE=1111, pulse WrCE=1000000 with data 0x01F4_4401 (N=500, MODE 0, EN=1) → WrAck high that cycle, and:
  - Format_O=1, OpEnQ=1, OpEnI=0, PWRDN=0.
  - DCLKIO 250 low / 250 high.
  - Data = LEVEL = 0.
- Write reg1=0x1234, reg2=0x123, then reg0=0x0032_0011 → N=50; Data on successive ticks 0x123, 0x246, 0x369, 0x08C.
- Write reg0=0x0032_0021 from EN=0 → triangle sequence 0x123, 0x246, 0x369, 0x3FF, 0x2DC.
- Write reg0=0x0032_0041 → down-ramp sequence 0x2DD, 0x1BA, ...; then MODE 8 (0x0032_0081) → Data = LEVEL = 0x234.
- Write reg5 with BE=0011, data 0xAABBCCDD → read reg5 = 0x0000CCDD, RdAck high.
- Write to reg4 → value ignored.
- Assert reset mid-run → all outputs return asynchronously to their reset values.

Source files
------------

// File: rtl/plb_dac_user_logic.sv
// rtl/plb_dac_user_logic.sv - PLB IPIF user-logic slave driving a 10-bit parallel DAC waveform generator
//
// Purpose:
//   Seven software registers reached through one-hot Bus2IP chip-enables.
//   The block generates a divided DAC sample clock and a 10-bit sample
//   stream: direct level, sawtooth, triangle, square or down-ramp.
//   It also drives the DAC static control pins from the control register.
//
// Register map (numeric bit 0 = LSB = Bus2IP_Data[31]):
//   reg0 CTRL   [0] EN, [7:4] MODE, [8] PinMD, [9] ClkMD, [10] Format_O,
//               [11] Format drive (Format_T = ~bit11), [12] PWRDN request,
//               [13] OpEnI, [14] OpEnQ, [31:16] divider N
//   reg1 LEVEL  [9:0]
//   reg2 STEP   [9:0]
//   reg3/5/6    read/write scratch
//   reg4 STATUS read-only: [9:0] current sample, [16] Format_I
//
// Ports:
//   Bus2IP_Clk      system clock
//   Bus2IP_Reset    asynchronous active-low reset
//   Bus2IP_Addr/CS/RNW  bus qualifiers, not needed (decode is by CE)
//   Bus2IP_Data     write data, index 0 = MSB
//   Bus2IP_BE       byte enables, BE[0] covers Data[0:7]
//   Bus2IP_RdCE     one-hot read enables, index 0 = reg0
//   Bus2IP_WrCE     one-hot write enables, index 0 = reg0
//   IP2Bus_Data     read data, index 0 = MSB
//   IP2Bus_RdAck/WrAck/Error  combinational handshake
//   IP2DAC_Data     10-bit offset-binary sample, index 0 = MSB
//   IP2DAC_DCLKIO/Clkout      divided sample clock
//   IP2DAC_PinMD/ClkMD/PWRDN/OpEnI/OpEnQ  DAC static control pins
//   IP2DAC_Format_I/O/T       Format pin tristate triple

module plb_dac_user_logic #(
    parameter int C_SLV_DWIDTH = 32,
    parameter int C_NUM_REG    = 7
) (
    input  logic                      Bus2IP_Clk,
    input  logic                      Bus2IP_Reset,
    input  logic [0:31]               Bus2IP_Addr,
    input  logic                      Bus2IP_CS,
    input  logic                      Bus2IP_RNW,
    input  logic [0:C_SLV_DWIDTH-1]   Bus2IP_Data,
    input  logic [0:C_SLV_DWIDTH/8-1] Bus2IP_BE,
    input  logic [0:C_NUM_REG-1]      Bus2IP_RdCE,
    input  logic [0:C_NUM_REG-1]      Bus2IP_WrCE,
    output logic [0:C_SLV_DWIDTH-1]   IP2Bus_Data,
    output logic                      IP2Bus_RdAck,
    output logic                      IP2Bus_WrAck,
    output logic                      IP2Bus_Error,
    output logic [0:9]                IP2DAC_Data,
    output logic                      IP2DAC_DCLKIO,
    output logic                      IP2DAC_Clkout,
    output logic                      IP2DAC_PinMD,
    output logic                      IP2DAC_ClkMD,
    output logic                      IP2DAC_PWRDN,
    output logic                      IP2DAC_OpEnI,
    output logic                      IP2DAC_OpEnQ,
    input  logic                      IP2DAC_Format_I,
    output logic                      IP2DAC_Format_O,
    output logic                      IP2DAC_Format_T
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Positional assignment turns the big-endian bus vectors into
    // conventional [31:0] / [3:0] numbering (bus index 0 lands on the MSB).
    logic [31:0] wdata;
    logic [3:0]  wbe;
    assign wdata = Bus2IP_Data;
    assign wbe   = Bus2IP_BE;

    logic [31:0] ctrl_q;
    logic [31:0] level_q;
    logic [31:0] step_q;
    logic [31:0] scr3_q;
    logic [31:0] scr5_q;
    logic [31:0] scr6_q;

    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = be[b] ? wd[b*8 +: 8] : cur[b*8 +: 8];
        end
        return r;
    endfunction

    // Software registers; reg4 is status and has no storage.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Reset) begin
        if (!Bus2IP_Reset) begin
            ctrl_q  <= '0;
            level_q <= '0;
            step_q  <= '0;
            scr3_q  <= '0;
            scr5_q  <= '0;
            scr6_q  <= '0;
        end else begin
            if (Bus2IP_WrCE[0]) ctrl_q  <= be_merge(ctrl_q,  wdata, wbe);
            if (Bus2IP_WrCE[1]) level_q <= be_merge(level_q, wdata, wbe);
            if (Bus2IP_WrCE[2]) step_q  <= be_merge(step_q,  wdata, wbe);
            if (Bus2IP_WrCE[3]) scr3_q  <= be_merge(scr3_q,  wdata, wbe);
            if (Bus2IP_WrCE[5]) scr5_q  <= be_merge(scr5_q,  wdata, wbe);
            if (Bus2IP_WrCE[6]) scr6_q  <= be_merge(scr6_q,  wdata, wbe);
        end
    end

    logic        en;
    logic [3:0]  mode;
    logic [15:0] div_n;
    logic [9:0]  level;
    logic [9:0]  step;
    assign en    = ctrl_q[0];
    assign mode  = ctrl_q[7:4];
    assign div_n = ctrl_q[31:16];
    assign level = level_q[9:0];
    assign step  = step_q[9:0];

    // Divider: N below 2 cannot produce both clock phases, so clamp to 2.
    logic [15:0] n_eff;
    logic [15:0] n_last;
    logic [15:0] n_half;
    assign n_eff  = (div_n < 16'd2) ? 16'd2 : div_n;
    assign n_last = n_eff - 16'd1;
    assign n_half = n_eff >> 1;

    logic [15:0] cnt_q;
    logic        dclk_q;
    logic        tick_q;

    // The >= compare lets a shrinking N wrap on the next cycle instead of
    // running the counter around 64k. tick_q delays the sample update one
    // clock so data changes once the DAC clock is already low.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Reset) begin
        if (!Bus2IP_Reset) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else if (!en) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q >= n_last) ? 16'd0 : cnt_q + 16'd1;
            dclk_q <= (cnt_q >= n_half);
            tick_q <= (cnt_q == n_last);
        end
    end

    // Waveform generator: direction state plus accumulator and sample.
    dir_t       dir_q;
    dir_t       dir_d;
    dir_t       dir_cur;
    logic [9:0] acc_q;
    logic [9:0] acc_d;
    logic [9:0] sample_q;
    logic [9:0] sample_d;
    logic [3:0] mode_q;
    logic [10:0] sum;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Reset) begin
        if (!Bus2IP_Reset) begin
            dir_q    <= DIR_UP;
            acc_q    <= '0;
            sample_q <= '0;
            mode_q   <= '0;
        end else begin
            dir_q    <= dir_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            mode_q   <= mode;
        end
    end

    always_comb begin
        dir_d    = dir_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        // A mode change restarts the triangle going up; ACC is kept.
        dir_cur  = (mode != mode_q) ? DIR_UP : dir_q;
        sum      = {1'b0, acc_q} + {1'b0, step};

        if (!en) begin
            dir_d    = DIR_UP;
            acc_d    = '0;
            sample_d = '0;
        end else begin
            dir_d = dir_cur;
            if (tick_q) begin
                case (mode)
                    4'd1: begin
                        acc_d    = sum[9:0];
                        sample_d = acc_d;
                    end
                    4'd2: begin
                        if (dir_cur == DIR_UP) begin
                            if (sum[10]) begin
                                acc_d = 10'h3FF;
                                dir_d = DIR_DOWN;
                            end else begin
                                acc_d = sum[9:0];
                            end
                        end else begin
                            if (acc_q < step) begin
                                acc_d = '0;
                                dir_d = DIR_UP;
                            end else begin
                                acc_d = acc_q - step;
                            end
                        end
                        sample_d = acc_d;
                    end
                    4'd3: begin
                        acc_d    = sum[9:0];
                        sample_d = acc_d[9] ? 10'd0 : level;
                    end
                    4'd4: begin
                        acc_d    = acc_q - step;
                        sample_d = acc_d;
                    end
                    default: begin
                        sample_d = level;
                    end
                endcase
            end
        end
    end

    // Read path.
    logic [31:0] status;
    logic [31:0] rd_data;
    assign status = {15'd0, IP2DAC_Format_I, 6'd0, sample_q};

    always_comb begin
        rd_data = '0;
        if (Bus2IP_RdCE[0]) rd_data = rd_data | ctrl_q;
        if (Bus2IP_RdCE[1]) rd_data = rd_data | level_q;
        if (Bus2IP_RdCE[2]) rd_data = rd_data | step_q;
        if (Bus2IP_RdCE[3]) rd_data = rd_data | scr3_q;
        if (Bus2IP_RdCE[4]) rd_data = rd_data | status;
        if (Bus2IP_RdCE[5]) rd_data = rd_data | scr5_q;
        if (Bus2IP_RdCE[6]) rd_data = rd_data | scr6_q;
    end

    assign IP2Bus_Data  = rd_data;
    assign IP2Bus_RdAck = |Bus2IP_RdCE;
    assign IP2Bus_WrAck = |Bus2IP_WrCE;
    assign IP2Bus_Error = 1'b0;

    // DAC pins.
    assign IP2DAC_Data     = sample_q;
    assign IP2DAC_DCLKIO   = dclk_q;
    assign IP2DAC_Clkout   = dclk_q;
    assign IP2DAC_PinMD    = ctrl_q[8];
    assign IP2DAC_ClkMD    = ctrl_q[9];
    assign IP2DAC_Format_O = ctrl_q[10];
    assign IP2DAC_Format_T = ~ctrl_q[11];
    assign IP2DAC_PWRDN    = ctrl_q[12] | ~en;
    assign IP2DAC_OpEnI    = ctrl_q[13] & en;
    assign IP2DAC_OpEnQ    = ctrl_q[14] & en;

    logic unused_ok;
    assign unused_ok = ^{Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, ctrl_q[3:1],
                         ctrl_q[15], level_q[31:10], step_q[31:10]};

endmodule

// File: tb/tb_plb_dac_user_logic.sv
// tb/tb_plb_dac_user_logic.sv - directed self-checking bench for plb_dac_user_logic

module tb_plb_dac_user_logic;

    logic        clk;
    logic        rst_n;
    logic [0:31] Bus2IP_Addr;
    logic        Bus2IP_CS;
    logic        Bus2IP_RNW;
    logic [0:31] Bus2IP_Data;
    logic [0:3]  Bus2IP_BE;
    logic [0:6]  Bus2IP_RdCE;
    logic [0:6]  Bus2IP_WrCE;
    logic [0:31] IP2Bus_Data;
    logic        IP2Bus_RdAck;
    logic        IP2Bus_WrAck;
    logic        IP2Bus_Error;
    logic [0:9]  IP2DAC_Data;
    logic        IP2DAC_DCLKIO;
    logic        IP2DAC_Clkout;
    logic        IP2DAC_PinMD;
    logic        IP2DAC_ClkMD;
    logic        IP2DAC_PWRDN;
    logic        IP2DAC_OpEnI;
    logic        IP2DAC_OpEnQ;
    logic        IP2DAC_Format_I;
    logic        IP2DAC_Format_O;
    logic        IP2DAC_Format_T;

    int n_cmp = 0;
    int n_err = 0;

    plb_dac_user_logic #(.C_SLV_DWIDTH(32), .C_NUM_REG(7)) dut (
        .Bus2IP_Clk      (clk),
        .Bus2IP_Reset    (rst_n),
        .Bus2IP_Addr     (Bus2IP_Addr),
        .Bus2IP_CS       (Bus2IP_CS),
        .Bus2IP_RNW      (Bus2IP_RNW),
        .Bus2IP_Data     (Bus2IP_Data),
        .Bus2IP_BE       (Bus2IP_BE),
        .Bus2IP_RdCE     (Bus2IP_RdCE),
        .Bus2IP_WrCE     (Bus2IP_WrCE),
        .IP2Bus_Data     (IP2Bus_Data),
        .IP2Bus_RdAck    (IP2Bus_RdAck),
        .IP2Bus_WrAck    (IP2Bus_WrAck),
        .IP2Bus_Error    (IP2Bus_Error),
        .IP2DAC_Data     (IP2DAC_Data),
        .IP2DAC_DCLKIO   (IP2DAC_DCLKIO),
        .IP2DAC_Clkout   (IP2DAC_Clkout),
        .IP2DAC_PinMD    (IP2DAC_PinMD),
        .IP2DAC_ClkMD    (IP2DAC_ClkMD),
        .IP2DAC_PWRDN    (IP2DAC_PWRDN),
        .IP2DAC_OpEnI    (IP2DAC_OpEnI),
        .IP2DAC_OpEnQ    (IP2DAC_OpEnQ),
        .IP2DAC_Format_I (IP2DAC_Format_I),
        .IP2DAC_Format_O (IP2DAC_Format_O),
        .IP2DAC_Format_T (IP2DAC_Format_T)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input int k, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        Bus2IP_Data = d;
        Bus2IP_BE   = be;
        Bus2IP_WrCE = 7'b1000000 >> k;
        #1;
        chk1("wrack", IP2Bus_WrAck, 1'b1);
        @(negedge clk);
        Bus2IP_WrCE = '0;
    endtask

    task automatic bus_read(input string tag, input int k, input logic [31:0] exp);
        @(negedge clk);
        Bus2IP_RdCE = 7'b1000000 >> k;
        #1;
        chk32(tag, IP2Bus_Data, exp);
        chk1({tag, "_rdack"}, IP2Bus_RdAck, 1'b1);
        Bus2IP_RdCE = '0;
    endtask

    task automatic chk_data(input string tag, input logic [9:0] exp);
        chk32(tag, {22'd0, IP2DAC_Data}, {22'd0, exp});
    endtask

    int high_cnt;
    int first_high;

    initial begin
        rst_n           = 1'b0;
        Bus2IP_Addr     = '0;
        Bus2IP_CS       = 1'b0;
        Bus2IP_RNW      = 1'b0;
        Bus2IP_Data     = '0;
        Bus2IP_BE       = 4'b1111;
        Bus2IP_RdCE     = '0;
        Bus2IP_WrCE     = '0;
        IP2DAC_Format_I = 1'b1;

        // Reset state
        step_n(2);
        #1;
        chk_data("rst_data", 10'd0);
        chk1("rst_fmt_t", IP2DAC_Format_T, 1'b1);
        chk1("rst_pwrdn", IP2DAC_PWRDN, 1'b1);
        chk1("rst_dclk", IP2DAC_DCLKIO, 1'b0);
        chk1("rst_wrack", IP2Bus_WrAck, 1'b0);
        chk1("rst_rdack", IP2Bus_RdAck, 1'b0);
        chk32("rst_idle_rd", IP2Bus_Data, 32'h0);
        for (int k = 0; k < 7; k++) begin
            bus_read($sformatf("rst_reg%0d", k), k, (k == 4) ? 32'h0001_0000 : 32'h0);
        end

        // N=500, MODE 0, EN=1, OpEnQ, Format_O
        @(negedge clk);
        rst_n = 1'b1;
        bus_write(0, 32'h01F4_4401, 4'b1111);
        chk1("run_fmt_o", IP2DAC_Format_O, 1'b1);
        chk1("run_openq", IP2DAC_OpEnQ, 1'b1);
        chk1("run_openi", IP2DAC_OpEnI, 1'b0);
        chk1("run_pwrdn", IP2DAC_PWRDN, 1'b0);
        chk1("run_fmt_t", IP2DAC_Format_T, 1'b1);
        chk1("run_err", IP2Bus_Error, 1'b0);
        high_cnt   = 0;
        first_high = 0;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            if (IP2DAC_DCLKIO && first_high == 0) first_high = k;
            if (IP2DAC_DCLKIO) high_cnt++;
        end
        chk32("dclk_high_cnt", high_cnt, 32'd250);
        chk32("dclk_first_high", first_high, 32'd251);
        chk1("clkout_mirror", IP2DAC_Clkout, IP2DAC_DCLKIO);
        @(negedge clk);
        chk1("dclk_wrap_low", IP2DAC_DCLKIO, 1'b0);
        chk_data("mode0_level0", 10'd0);

        // Sawtooth, N=50
        bus_write(1, 32'h0000_1234, 4'b1111);
        bus_write(2, 32'h0000_0123, 4'b1111);
        bus_write(0, 32'h0, 4'b1111);
        step_n(1);
        chk1("dis_dclk", IP2DAC_DCLKIO, 1'b0);
        chk1("dis_pwrdn", IP2DAC_PWRDN, 1'b1);
        bus_write(0, 32'h0032_0011, 4'b1111);
        step_n(50);
        chk_data("saw_pre", 10'h000);
        step_n(1);
        chk_data("saw0", 10'h123);
        step_n(50);
        chk_data("saw1", 10'h246);
        step_n(50);
        chk_data("saw2", 10'h369);
        step_n(50);
        chk_data("saw3_wrap", 10'h08C);

        // Triangle from EN=0
        bus_write(0, 32'h0, 4'b1111);
        step_n(1);
        chk_data("dis_data", 10'd0);
        bus_write(0, 32'h0032_0021, 4'b1111);
        step_n(51);
        chk_data("tri0", 10'h123);
        step_n(50);
        chk_data("tri1", 10'h246);
        step_n(50);
        chk_data("tri2", 10'h369);
        step_n(50);
        chk_data("tri3_top", 10'h3FF);
        step_n(50);
        chk_data("tri4_down", 10'h2DC);

        // Down-ramp from EN=0, then MODE 8 falls back to LEVEL
        bus_write(0, 32'h0, 4'b1111);
        step_n(1);
        bus_write(0, 32'h0032_0041, 4'b1111);
        step_n(51);
        chk_data("down0", 10'h2DD);
        step_n(50);
        chk_data("down1", 10'h1BA);
        bus_write(0, 32'h0032_0081, 4'b1111);
        step_n(50);
        chk_data("mode8_level", 10'h234);

        // Register readback, byte enables, read-only status
        bus_read("rd_reg0", 0, 32'h0032_0081);
        bus_read("rd_reg1", 1, 32'h0000_1234);
        bus_read("rd_reg2", 2, 32'h0000_0123);
        bus_read("rd_status", 4, 32'h0001_0234);
        bus_write(5, 32'hAABB_CCDD, 4'b0011);
        bus_read("rd_reg5_be", 5, 32'h0000_CCDD);
        bus_write(3, 32'h1122_3344, 4'b1000);
        bus_read("rd_reg3_be", 3, 32'h1100_0000);
        bus_write(6, 32'hDEAD_BEEF, 4'b1111);
        bus_read("rd_reg6", 6, 32'hDEAD_BEEF);
        bus_write(4, 32'hFFFF_FFFF, 4'b1111);
        bus_read("rd_status_ro", 4, 32'h0001_0234);

        // N=0 clamps to 2
        bus_write(0, 32'h0, 4'b1111);
        step_n(1);
        bus_write(0, 32'h0000_0001, 4'b1111);
        step_n(1);
        chk1("n0_dclk_e1", IP2DAC_DCLKIO, 1'b0);
        step_n(1);
        chk1("n0_dclk_e2", IP2DAC_DCLKIO, 1'b1);
        step_n(1);
        chk1("n0_dclk_e3", IP2DAC_DCLKIO, 1'b0);
        chk_data("n0_data", 10'h234);
        step_n(1);
        chk1("n0_dclk_e4", IP2DAC_DCLKIO, 1'b1);

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_dclk", IP2DAC_DCLKIO, 1'b0);
        chk_data("arst_data", 10'd0);
        chk1("arst_pwrdn", IP2DAC_PWRDN, 1'b1);
        chk1("arst_fmt_t", IP2DAC_Format_T, 1'b1);
        bus_read("arst_reg1", 1, 32'h0);
        bus_read("arst_reg6", 6, 32'h0);
        bus_read("arst_status", 4, 32'h0001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
